// File: rtl/audio_frame_sequencer_if.sv
// audio_frame_sequencer_if
// Groups the run-control, store and processor signals of the audio frame
// sequencer into one bundle.
//   master : the sequencer side (drives store addresses and processor strobes)
//   slave  : the environment side (drives go/config, store data, processor
//            done/data_out)
interface audio_frame_sequencer_if #(
    parameter int DATA_W  = 512,
    parameter int IDX_W   = 6,
    parameter int ADDR_W  = 16,
    parameter int FRAME_W = 8
);
    // run control
    logic               go;
    logic [FRAME_W-1:0] num_frames;
    logic [ADDR_W-1:0]  src_base;
    logic [ADDR_W-1:0]  dst_base;
    logic               busy;
    logic [FRAME_W-1:0] frames_done;
    logic               run_done;
    logic               error;
    // source store (1-cycle read latency)
    logic [ADDR_W-1:0]  src_addr;
    logic [DATA_W-1:0]  src_data;
    // processor
    logic               proc_data_wr_en;
    logic [IDX_W-1:0]   proc_input_index;
    logic [DATA_W-1:0]  proc_data_in;
    logic               proc_start;
    logic               proc_done;
    logic [IDX_W-1:0]   proc_output_index;
    logic [DATA_W-1:0]  proc_data_out;
    // result store
    logic               dst_wr_en;
    logic [ADDR_W-1:0]  dst_addr;
    logic [DATA_W-1:0]  dst_data;

    modport master (
        input  go, num_frames, src_base, dst_base, src_data, proc_done, proc_data_out,
        output busy, frames_done, run_done, error, src_addr,
               proc_data_wr_en, proc_input_index, proc_data_in, proc_start,
               proc_output_index, dst_wr_en, dst_addr, dst_data
    );

    modport slave (
        output go, num_frames, src_base, dst_base, src_data, proc_done, proc_data_out,
        input  busy, frames_done, run_done, error, src_addr,
               proc_data_wr_en, proc_input_index, proc_data_in, proc_start,
               proc_output_index, dst_wr_en, dst_addr, dst_data
    );
endinterface

// File: rtl/audio_frame_sequencer.sv
// audio_frame_sequencer
// Streams num_frames frames of WORDS bus words from a source store into the
// audio processor, pulses proc_start, waits for the rising edge of proc_done,
// then drains the processed words into a result store. Frame f uses word
// addresses base + f*WORDS + k (modulo 2^ADDR_W).
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (all outputs drop to 0 immediately)
//   bus   : audio_frame_sequencer_if.master -- go/num_frames/src_base/dst_base
//           in, busy/frames_done/run_done/error out, source store read port,
//           processor load/start/done/unload port, result store write port.
//
// Build option:
//   SEQ_WATCHDOG_EN : when defined, a WAIT-state watchdog of TIMEOUT_CYCLES
//                     sets the sticky error flag and ends the run without
//                     draining. When undefined, error is tied 0 and WAIT
//                     waits indefinitely.
module audio_frame_sequencer #(
    parameter int DATA_W         = 512,
    parameter int WORDS          = 64,
    parameter int IDX_W          = 6,
    parameter int ADDR_W         = 16,
    parameter int FRAME_W        = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    audio_frame_sequencer_if.master bus
);
    // word counter needs to reach WORDS (the extra FILL write cycle)
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WORDS - 1);

    if (((1 << IDX_W) < WORDS) || (TIMEOUT_CYCLES < 1)) begin : g_param_chk
        $error("audio_frame_sequencer: IDX_W too small for WORDS or TIMEOUT_CYCLES < 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_START, S_WAIT, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] num_q;
    logic [FRAME_W-1:0] frames_q;
    logic [FRAME_W-1:0] frames_inc;
    logic [ADDR_W-1:0]  src_base_q;
    logic [ADDR_W-1:0]  dst_base_q;
    logic [ADDR_W-1:0]  frame_off;   // f*WORDS, wraps with the address space
    logic [CNT_W-1:0]   wcnt;
    logic               done_q;
    logic               done_edge;
    logic               accept;
    logic               wd_expire;
    logic               err_q;

    assign accept     = (state == S_IDLE) && bus.go;
    assign frames_inc = frames_q + FRAME_W'(1);
    // done_q samples proc_done every cycle, so a level already high when
    // WAIT is entered is seen as prev=1 and does not count as completion.
    assign done_edge  = bus.proc_done && !done_q;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wd_cnt <= '0;
        else if (state == S_WAIT)  wd_cnt <= wd_cnt + WD_W'(1);
        else                       wd_cnt <= '0;
    end

    // fires in the TIMEOUT_CYCLES-th WAIT cycle; a coincident edge wins
    assign wd_expire = (state == S_WAIT) && !done_edge &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         err_q <= 1'b0;
        else if (accept)    err_q <= 1'b0;
        else if (wd_expire) err_q <= 1'b1;
    end
`else
    assign wd_expire = 1'b0;
    assign err_q     = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.go) state_nxt = (bus.num_frames == '0) ? S_DONE : S_FILL;
            S_FILL:  if (wcnt == FILL_LAST) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_edge)      state_nxt = S_DRAIN;
                else if (wd_expire) state_nxt = S_DONE;
            end
            S_DRAIN: if (wcnt == DRAIN_LAST) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = (frames_inc == num_q) ? S_DONE : S_FILL;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q      <= '0;
            frames_q   <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            frame_off  <= '0;
            wcnt       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= bus.proc_done;
            case (state)
                S_IDLE: if (bus.go) begin
                    num_q      <= bus.num_frames;
                    src_base_q <= bus.src_base;
                    dst_base_q <= bus.dst_base;
                    frames_q   <= '0;
                    frame_off  <= '0;
                    wcnt       <= '0;
                end
                S_FILL:  wcnt <= (wcnt == FILL_LAST)  ? '0 : wcnt + CNT_W'(1);
                S_DRAIN: wcnt <= (wcnt == DRAIN_LAST) ? '0 : wcnt + CNT_W'(1);
                S_NEXT: begin
                    frames_q  <= frames_inc;
                    frame_off <= frame_off + ADDR_W'(WORDS);
                end
                default: ;
            endcase
        end
    end

    // outputs: everything is gated by state so reset forces them all to 0
    always_comb begin
        bus.src_addr          = '0;
        bus.proc_data_wr_en   = 1'b0;
        bus.proc_input_index  = '0;
        bus.proc_data_in      = '0;
        bus.proc_start        = 1'b0;
        bus.proc_output_index = '0;
        bus.dst_wr_en         = 1'b0;
        bus.dst_addr          = '0;
        bus.dst_data          = '0;
        bus.run_done          = 1'b0;
        case (state)
            S_FILL: begin
                // read for word wcnt, write of word wcnt-1 from last cycle's read
                if (wcnt != FILL_LAST)
                    bus.src_addr = src_base_q + frame_off + ADDR_W'(wcnt);
                if (wcnt != '0) begin
                    bus.proc_data_wr_en  = 1'b1;
                    bus.proc_input_index = IDX_W'(wcnt - CNT_W'(1));
                    bus.proc_data_in     = bus.src_data;
                end
            end
            S_START: bus.proc_start = 1'b1;
            S_DRAIN: begin
                bus.proc_output_index = IDX_W'(wcnt);
                bus.dst_wr_en         = 1'b1;
                bus.dst_addr          = dst_base_q + frame_off + ADDR_W'(wcnt);
                bus.dst_data          = bus.proc_data_out;
            end
            S_DONE:  bus.run_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
    assign bus.frames_done = frames_q;
    assign bus.error       = err_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Scoreboard bench for audio_frame_sequencer: each run pushes the expected
// processor writes, result-store writes and end-of-run status into queues;
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_audio_frame_sequencer;
    localparam int DATA_W = 512, WORDS = 64, IDX_W = 6, ADDR_W = 16, FRAME_W = 8;
    localparam int TO = 100;
    localparam int RUN_BOUND = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_frame_sequencer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .FRAME_W(FRAME_W)) bus();

    audio_frame_sequencer #(
        .DATA_W(DATA_W), .WORDS(WORDS), .IDX_W(IDX_W), .ADDR_W(ADDR_W),
        .FRAME_W(FRAME_W), .TIMEOUT_CYCLES(TO)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0, checks = 0;
    int unsigned seed;

    function automatic void chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // source store contents as a pure function of address
    function automatic logic [DATA_W-1:0] src_word(logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W/32; i++)
            w[i*32 +: 32] = ({16'(a), 16'(i)} * 32'h9E3779B1) ^ seed;
        return w;
    endfunction

    // what the processor model does to word k of a frame
    function automatic logic [DATA_W-1:0] xform(logic [DATA_W-1:0] w, int k);
        return w ^ {(DATA_W/32){32'hC3A5_0000 + 32'(k)}};
    endfunction

    // ---------------- environment models ----------------
    always @(posedge clk) bus.src_data <= src_word(bus.src_addr);

    logic [DATA_W-1:0] in_buf  [WORDS];
    logic [DATA_W-1:0] out_buf [WORDS];
    int   pcnt = 0;
    int   drop_at = 0;      // cycles after start when done falls (0 = at start)
    int   rise_at = 10;     // cycles after start when done rises (-1 = never)
    bit   finished = 1'b0;  // processor has really completed the current frame
    bit   preset_high = 1'b0;
    logic done_r = 1'b0;

    assign bus.proc_done     = done_r;
    assign bus.proc_data_out = out_buf[bus.proc_output_index];

    initial for (int i = 0; i < WORDS; i++) begin in_buf[i] = '0; out_buf[i] = '0; end

    always @(posedge clk) begin
        if (bus.proc_data_wr_en) in_buf[bus.proc_input_index] <= bus.proc_data_in;
        if (preset_high) done_r <= 1'b1;
        if (bus.proc_start) begin
            for (int i = 0; i < WORDS; i++) out_buf[i] <= xform(in_buf[i], i);
            finished <= 1'b0;
            pcnt <= 1;
            if (drop_at == 0) done_r <= 1'b0;
        end else if (pcnt > 0) begin
            pcnt <= pcnt + 1;
            if (pcnt == drop_at) done_r <= 1'b0;
            if (pcnt == rise_at) begin done_r <= 1'b1; finished <= 1'b1; pcnt <= 0; end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [IDX_W-1:0] idx; logic [DATA_W-1:0] data; } wr_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } dw_t;
    typedef struct { logic [FRAME_W-1:0] frames; logic err; } rd_t;
    wr_t wr_q[$];
    dw_t dst_q[$];
    rd_t rd_q[$];
    int  starts = 0, run_dones = 0, dst_seen = 0;

    // reference: frame f word k comes from src_base+f*WORDS+k and lands at dst_base+f*WORDS+k
    function automatic void expect_run(int n, logic [ADDR_W-1:0] sb, logic [ADDR_W-1:0] db, bit to);
        wr_t w; dw_t d; rd_t r;
        int nf = (to && n > 0) ? 1 : n;
        for (int f = 0; f < nf; f++)
            for (int k = 0; k < WORDS; k++) begin
                w.idx  = IDX_W'(k);
                w.data = src_word(ADDR_W'(int'(sb) + f*WORDS + k));
                wr_q.push_back(w);
                if (!to) begin
                    d.addr = ADDR_W'(int'(db) + f*WORDS + k);
                    d.data = xform(w.data, k);
                    dst_q.push_back(d);
                end
            end
        r.frames = to ? '0 : FRAME_W'(n);
        r.err    = to;
        rd_q.push_back(r);
    endfunction

    wr_t mw; dw_t md; rd_t mr;
    always @(negedge clk) if (rst_n) begin
        if (bus.proc_data_wr_en) begin
            if (wr_q.size() == 0) chk("unexpected_proc_wr", DATA_W'(bus.proc_input_index), '1);
            else begin
                mw = wr_q.pop_front();
                chk("proc_input_index", DATA_W'(bus.proc_input_index), DATA_W'(mw.idx));
                chk("proc_data_in", bus.proc_data_in, mw.data);
            end
        end
        if (bus.dst_wr_en) begin
            dst_seen++;
            chk("drain_after_done_edge", DATA_W'(finished), DATA_W'(1));
            if (dst_q.size() == 0) chk("unexpected_dst_wr", DATA_W'(bus.dst_addr), '1);
            else begin
                md = dst_q.pop_front();
                chk("dst_addr", DATA_W'(bus.dst_addr), DATA_W'(md.addr));
                chk("dst_data", bus.dst_data, md.data);
            end
        end
        if (bus.proc_start) starts++;
        if (bus.run_done) begin
            run_dones++;
            chk("busy_at_run_done", DATA_W'(bus.busy), '0);
            if (rd_q.size() == 0) chk("unexpected_run_done", DATA_W'(1), '0);
            else begin
                mr = rd_q.pop_front();
                chk("frames_done", DATA_W'(bus.frames_done), DATA_W'(mr.frames));
                chk("error", DATA_W'(bus.error), DATA_W'(mr.err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_go(input int n, input logic [ADDR_W-1:0] sb, input logic [ADDR_W-1:0] db);
        @(posedge clk); #1;
        bus.num_frames = FRAME_W'(n);
        bus.src_base   = sb;
        bus.dst_base   = db;
        bus.go         = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
    endtask

    task automatic run(input string name, input int n, input logic [ADDR_W-1:0] sb,
                       input logic [ADDR_W-1:0] db, input bit to, input bit poke);
        int s0, r0, cyc, exp_starts, exp_frames;
        s0 = starts; r0 = run_dones; cyc = 0;
        exp_starts = (n == 0) ? 0 : (to ? 1 : n);
        exp_frames = to ? 0 : n;
        expect_run(n, sb, db, to);
        do_go(n, sb, db);
        while (run_dones == r0 && cyc < RUN_BOUND) begin
            @(posedge clk); cyc++;
            if (poke && cyc == 40) begin
                // go with different settings while busy must be ignored
                #1; bus.go = 1'b1; bus.num_frames = FRAME_W'(9); bus.src_base = 16'h7000;
                @(posedge clk); #1; bus.go = 1'b0; cyc++;
            end
        end
        chk({name, "_run_done_seen"}, DATA_W'(cyc < RUN_BOUND), DATA_W'(1));
        if (n == 0) chk({name, "_zero_frame_latency_ok"}, DATA_W'(cyc <= 3), DATA_W'(1));
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_run_done_count"}, DATA_W'(run_dones - r0), DATA_W'(1));
        chk({name, "_start_count"}, DATA_W'(starts - s0), DATA_W'(exp_starts));
        chk({name, "_wr_left"}, DATA_W'(wr_q.size()), '0);
        chk({name, "_dst_left"}, DATA_W'(dst_q.size()), '0);
        chk({name, "_idle_busy"}, DATA_W'(bus.busy), '0);
        chk({name, "_frames_done_hold"}, DATA_W'(bus.frames_done), DATA_W'(exp_frames));
        chk({name, "_error_hold"}, DATA_W'(bus.error), DATA_W'(to));
    endtask

    initial begin
        int cyc, d0;
        seed = $urandom;
        bus.go = 1'b0; bus.num_frames = '0; bus.src_base = '0; bus.dst_base = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", DATA_W'({bus.busy, bus.run_done, bus.error, bus.proc_start,
                                      bus.proc_data_wr_en, bus.dst_wr_en}), '0);
        chk("reset_frames_done", DATA_W'(bus.frames_done), '0);
        chk("reset_src_addr", DATA_W'(bus.src_addr), '0);
        @(negedge clk) rst_n = 1'b1;

        run("single", 1, 16'h0000, 16'h0100, 1'b0, 1'b0);
        run("four", 4, 16'h0000, 16'h0100, 1'b0, 1'b0);
        run("zero", 0, 16'h0040, 16'h0200, 1'b0, 1'b0);

        // done already high before start: must wait for it to fall and re-rise
        drop_at = 5; rise_at = 15;
        @(posedge clk); #1 preset_high = 1'b1;
        @(posedge clk); #1 preset_high = 1'b0;
        run("held_done", 1, 16'(($urandom)), 16'(($urandom)), 1'b0, 1'b1);
        drop_at = 0; rise_at = 10;

        run("wrap", 2, 16'hFFE0, 16'hFFF0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            run("random", int'($urandom_range(1, 3)), 16'(($urandom)), 16'(($urandom)), 1'b0, 1'b0);

        // asynchronous reset in the middle of a drain
        expect_run(2, 16'h0400, 16'h0800, 1'b0);
        d0 = dst_seen; cyc = 0;
        do_go(2, 16'h0400, 16'h0800);
        while (dst_seen - d0 < 20 && cyc < RUN_BOUND) begin @(posedge clk); cyc++; end
        chk("reset_test_reached_drain", DATA_W'(cyc < RUN_BOUND), DATA_W'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_strobes", DATA_W'({bus.busy, bus.run_done, bus.error, bus.proc_start,
                                             bus.proc_data_wr_en, bus.dst_wr_en}), '0);
        chk("midrun_reset_addr", DATA_W'({bus.src_addr, bus.dst_addr, bus.frames_done,
                                          bus.proc_input_index, bus.proc_output_index}), '0);
        chk("midrun_reset_data", bus.proc_data_in | bus.dst_data, '0);
        wr_q.delete(); dst_q.delete(); rd_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run("post_reset", 1, 16'h1234, 16'h4321, 1'b0, 1'b0);

`ifdef SEQ_WATCHDOG_EN
        rise_at = -1;
        run("watchdog", 3, 16'h0000, 16'h0100, 1'b1, 1'b0);
        rise_at = 10;
        run("after_watchdog", 1, 16'h0000, 16'h0100, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
